// File: rtl/led_count_ctrl_pkg.sv
// Shared definitions for the LED counter front-end.
//   - step_state_e : step FSM encoding (IDLE / PRESSED / AUTO)
//   - BOARD_*      : timing constants for the 12 MHz board clock
//   - SIM_*        : scaled-down timing constants for simulation
//   - ctr_width()  : width of a counter that must hold 0..n-1
package led_count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_AUTO    = 2'd2
    } step_state_e;

    // 12 MHz board clock: 10 ms debounce, 0.5 s hold, 0.1 s repeat.
    localparam int unsigned BOARD_DEBOUNCE_CYCLES = 120000;
    localparam int unsigned BOARD_HOLD_CYCLES     = 6000000;
    localparam int unsigned BOARD_TICK_CYCLES     = 1200000;

    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SIM_HOLD_CYCLES     = 20;
    localparam int unsigned SIM_TICK_CYCLES     = 5;

    // Never returns 0 so degenerate parameter values still give a legal vector.
    function automatic int unsigned ctr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_count_ctrl_btn_debounce.sv
// Synchronizer + debouncer for one raw active-low push button.
//   clk, rst       : clock, asynchronous active-high reset
//   btn_n          : raw button, active low, asynchronous to clk
//   level          : debounced level, 1 = pressed
//   press_pulse    : 1-cycle pulse on released->pressed debounced transition
//   release_pulse  : 1-cycle pulse on pressed->released debounced transition
// A stable raw edge produces its pulse 2 + DEBOUNCE_CYCLES cycles later.
module btn_debounce
    import led_count_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned   CW       = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          pressed_q, pressed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          sync_pressed;

    assign sync_pressed = ~sync2_q;

    // Count consecutive cycles where the synchronized input disagrees with
    // the debounced level; any agreement restarts the count.
    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        if (sync_pressed != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = sync_pressed;
                press_d   = sync_pressed;
                rel_d     = ~sync_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
        end
    end

    assign level         = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/led_count_ctrl.sv
// LED counter controller driven by two raw active-low buttons.
//   clk, rst    : clock, asynchronous active-high reset
//   btn_step_n  : step button (short press = one step, long press = auto-repeat)
//   btn_dir_n   : direction button, each press toggles dir
//   led         : WIDTH-bit counter value
//   dir         : 0 = count up, 1 = count down
//   auto        : high while auto-repeating
module led_count_ctrl
    import led_count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = BOARD_HOLD_CYCLES,
    parameter int unsigned TICK_CYCLES     = BOARD_TICK_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step_n,
    input  logic             btn_dir_n,
    output logic [WIDTH-1:0] led,
    output logic             dir,
    output logic             auto
);

    localparam int unsigned   HW        = ctr_width(HOLD_CYCLES);
    localparam int unsigned   TW        = ctr_width(TICK_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic step_press, step_release, dir_press;
    logic step_level_unused, dir_level_unused, dir_release_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_step_n),
        .level         (step_level_unused),
        .press_pulse   (step_press),
        .release_pulse (step_release)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_db (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_dir_n),
        .level         (dir_level_unused),
        .press_pulse   (dir_press),
        .release_pulse (dir_release_unused)
    );

    step_state_e      state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             dir_q, dir_d;
    logic             auto_q, auto_d;
    logic             do_step;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tick_d  = tick_q;
        do_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (step_press) begin
                    state_d = ST_PRESSED;
                    hold_d  = '0;
                end
            end
            ST_PRESSED: begin
                // Saturating hold timer; reaching HOLD_LAST leaves the state.
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
                if (step_release) begin
                    do_step = 1'b1;
                    state_d = ST_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    do_step = 1'b1;
                    state_d = ST_AUTO;
                    tick_d  = '0;
                end
            end
            ST_AUTO: begin
                // A wrap that coincides with release still steps.
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    do_step = 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                if (step_release) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Step uses the current dir so a coincident toggle affects the next step only.
    always_comb begin
        dir_d = dir_q ^ dir_press;
        led_d = led_q;
        if (do_step) begin
            led_d = dir_q ? (led_q - 1'b1) : (led_q + 1'b1);
        end
        auto_d = (state_d == ST_AUTO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            tick_q  <= '0;
            led_q   <= '0;
            dir_q   <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            auto_q  <= auto_d;
        end
    end

    assign led  = led_q;
    assign dir  = dir_q;
    assign auto = auto_q;

endmodule

// File: tb/tb_led_count_ctrl.sv
// Directed self-checking bench for led_count_ctrl at simulation timing
// (DEBOUNCE 4, HOLD 20, TICK 5).
module tb_led_count_ctrl;
    import led_count_ctrl_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn_step_n = 1'b1;
    logic         btn_dir_n  = 1'b1;
    logic [W-1:0] led;
    logic         dir;
    logic         auto;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_count_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (SIM_HOLD_CYCLES),
        .TICK_CYCLES     (SIM_TICK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step_n (btn_step_n),
        .btn_dir_n  (btn_dir_n),
        .led        (led),
        .dir        (dir),
        .auto       (auto)
    );

    // Advance n cycles; leaves time at 1 unit after a rising edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic short_press();
        btn_step_n = 1'b0;
        cycles(10);
        btn_step_n = 1'b1;
        cycles(12);
    endtask

    task automatic toggle_dir();
        btn_dir_n = 1'b0;
        cycles(8);
        btn_dir_n = 1'b1;
        cycles(8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        checks++; if (led !== 4'd0) begin failures++; $display("FAIL reset_led got=%0d exp=0", led); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%b exp=0", dir); end
        checks++; if (auto !== 1'b0) begin failures++; $display("FAIL reset_auto got=%b exp=0", auto); end
        rst = 1'b0;
        cycles(10);
        checks++; if (led !== 4'd0) begin failures++; $display("FAIL idle_led got=%0d exp=0", led); end
        checks++; if (auto !== 1'b0) begin failures++; $display("FAIL idle_auto got=%b exp=0", auto); end
    endtask

    // Bounced short press; release event lands 6 cycles after the last bounce.
    task automatic test_short_press();
        int auto_seen = 0;
        btn_step_n = 1'b0; cycles(1);
        btn_step_n = 1'b1; cycles(1);
        btn_step_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            if (auto === 1'b1) auto_seen++;
        end
        checks++; if (led !== 4'd0) begin failures++; $display("FAIL short_no_early_step got=%0d exp=0", led); end
        btn_step_n = 1'b1; cycles(1);
        btn_step_n = 1'b0; cycles(1);
        btn_step_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cycles(1);
            if (auto === 1'b1) auto_seen++;
            if (k == 6) begin
                checks++; if (led !== 4'd0) begin failures++; $display("FAIL short_before_rel got=%0d exp=0", led); end
            end
            if (k == 7) begin
                checks++; if (led !== 4'd1) begin failures++; $display("FAIL short_rel_cycle got=%0d exp=1", led); end
            end
        end
        checks++; if (led !== 4'd1) begin failures++; $display("FAIL short_final got=%0d exp=1", led); end
        checks++; if (auto_seen !== 0) begin failures++; $display("FAIL short_auto_seen got=%0d exp=0", auto_seen); end
    endtask

    task automatic test_long_press();
        rst = 1'b1; cycles(2);
        rst = 1'b0; cycles(2);
        btn_step_n = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            cycles(1);
            if (k == 26) begin
                checks++; if (auto !== 1'b0) begin failures++; $display("FAIL long_auto_early got=%b exp=0", auto); end
                checks++; if (led !== 4'd0) begin failures++; $display("FAIL long_led_early got=%0d exp=0", led); end
            end
            if (k == 27) begin
                checks++; if (auto !== 1'b1) begin failures++; $display("FAIL long_auto_enter got=%b exp=1", auto); end
                checks++; if (led !== 4'd1) begin failures++; $display("FAIL long_entry_step got=%0d exp=1", led); end
            end
            if (k == 31) begin
                checks++; if (led !== 4'd1) begin failures++; $display("FAIL long_pre_tick got=%0d exp=1", led); end
            end
            if (k == 32) begin
                checks++; if (led !== 4'd2) begin failures++; $display("FAIL long_first_tick got=%0d exp=2", led); end
            end
            if (k == 56) begin
                checks++; if (auto !== 1'b1 || led !== 4'd6) begin
                    failures++; $display("FAIL long_pre_release got=auto%b/led%0d exp=auto1/led6", auto, led);
                end
            end
            if (k == 57) begin
                checks++; if (auto !== 1'b0 || led !== 4'd7) begin
                    failures++; $display("FAIL long_release got=auto%b/led%0d exp=auto0/led7", auto, led);
                end
            end
            if (k == 50) btn_step_n = 1'b1;
        end
        checks++; if (led !== 4'd7 || auto !== 1'b0) begin
            failures++; $display("FAIL long_after got=auto%b/led%0d exp=auto0/led7", auto, led);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) short_press();
        checks++; if (led !== 4'd15) begin failures++; $display("FAIL wrap_setup got=%0d exp=15", led); end
        short_press();
        checks++; if (led !== 4'd0) begin failures++; $display("FAIL wrap_up got=%0d exp=0", led); end
        toggle_dir();
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL wrap_dir got=%b exp=1", dir); end
        short_press();
        checks++; if (led !== 4'd15) begin failures++; $display("FAIL wrap_down got=%0d exp=15", led); end
    endtask

    task automatic test_simultaneous();
        toggle_dir();
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL simul_dir_setup got=%b exp=0", dir); end
        for (int i = 0; i < 4; i++) short_press();
        checks++; if (led !== 4'd3) begin failures++; $display("FAIL simul_led_setup got=%0d exp=3", led); end
        btn_step_n = 1'b0;
        cycles(10);
        btn_step_n = 1'b1;
        btn_dir_n  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cycles(1);
            if (k == 6) begin
                checks++; if (led !== 4'd3 || dir !== 1'b0) begin
                    failures++; $display("FAIL simul_before got=led%0d/dir%b exp=led3/dir0", led, dir);
                end
            end
            if (k == 7) begin
                checks++; if (led !== 4'd4 || dir !== 1'b1) begin
                    failures++; $display("FAIL simul_event got=led%0d/dir%b exp=led4/dir1", led, dir);
                end
            end
        end
        btn_dir_n = 1'b1;
        cycles(10);
        checks++; if (led !== 4'd4 || dir !== 1'b1) begin
            failures++; $display("FAIL simul_dir_release got=led%0d/dir%b exp=led4/dir1", led, dir);
        end
        short_press();
        checks++; if (led !== 4'd3) begin failures++; $display("FAIL simul_next_step got=%0d exp=3", led); end
    endtask

    task automatic test_reset_mid_auto();
        int n = 0;
        int early_steps = 0;
        btn_step_n = 1'b0;
        while (led !== 4'd9 && n < 400) begin
            cycles(1);
            n++;
        end
        checks++; if (led !== 4'd9 || auto !== 1'b1) begin
            failures++; $display("FAIL midauto_reach got=led%0d/auto%b exp=led9/auto1 after %0d cycles", led, auto, n);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (led !== 4'd0 || auto !== 1'b0 || dir !== 1'b0) begin
            failures++; $display("FAIL midauto_async got=led%0d/auto%b/dir%b exp=led0/auto0/dir0", led, auto, dir);
        end
        cycles(3);
        checks++; if (led !== 4'd0 || auto !== 1'b0) begin
            failures++; $display("FAIL midauto_in_reset got=led%0d/auto%b exp=led0/auto0", led, auto);
        end
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cycles(1);
            if (led !== 4'd0 || auto !== 1'b0) early_steps++;
        end
        checks++; if (early_steps !== 0) begin
            failures++; $display("FAIL held_no_step got=%0d exp=0", early_steps);
        end
        btn_step_n = 1'b1;
        cycles(12);
        checks++; if (led !== 4'd1 || auto !== 1'b0) begin
            failures++; $display("FAIL held_then_release got=led%0d/auto%b exp=led1/auto0", led, auto);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_short_press();
        test_long_press();
        test_wrap();
        test_simultaneous();
        test_reset_mid_auto();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
